// File: rtl/l2_bank_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : l2_arb_pkg
// Purpose  : Shared constants, state encoding and helpers for the L2 bank
//            port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package l2_arb_pkg;

  // Default bank data width and the matching byte-enable width
  localparam int c_DATA_W_DEF = 32;
  localparam int c_BE_W       = c_DATA_W_DEF / 8;

  // Sequencer states
  typedef logic [1:0] arb_state_t;
  localparam arb_state_t c_ST_IDLE  = 2'd0;
  localparam arb_state_t c_ST_CLEAR = 2'd1;
  localparam arb_state_t c_ST_DONE  = 2'd2;

  // One-hot (up to 8 ports) to binary index; all-zero input maps to 0
  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) r = 3'(i);
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/l2_bank_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : l2_bank_port_arbiter_if
// Purpose  : Requester-side bus of the L2 bank arbiter. Signal names keep the
//            arbiter's point of view (_i into the arbiter, _o out of it).
// Revision : 1.0 - initial release
// ============================================================================
interface l2_bank_port_arbiter_if #(
  parameter int N_PORTS = 4,
  parameter int ADDR_W  = 15,
  parameter int DATA_W  = 32
);
  logic [N_PORTS-1:0]          req_i;
  logic [N_PORTS-1:0]          we_i;
  logic [N_PORTS*DATA_W/8-1:0] be_i;
  logic [N_PORTS*ADDR_W-1:0]   addr_i;
  logic [N_PORTS*DATA_W-1:0]   wdata_i;
  logic [N_PORTS-1:0]          gnt_o;
  logic [N_PORTS-1:0]          rvalid_o;
  logic [DATA_W-1:0]           rdata_o;

  // Requesters drive the request side and observe grants/responses
  modport master (
    output req_i, we_i, be_i, addr_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o
  );

  // The arbiter consumes requests and produces grants/responses
  modport slave (
    input  req_i, we_i, be_i, addr_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o
  );
endinterface
`default_nettype wire

// File: rtl/l2_bank_port_arbiter_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : l2_rr_arb
// Purpose  : Combinational round-robin arbiter. Grants the first requester at
//            or after the pointer, wrapping cyclically.
// Revision : 1.0 - initial release
// ============================================================================
module l2_rr_arb
  import l2_arb_pkg::*;
#(
  parameter int N_PORTS = 4,
  parameter int IDX_W   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  wire logic [N_PORTS-1:0] i_req,
  input  wire logic [IDX_W-1:0]   i_ptr,
  input  wire logic               i_en,
  output logic      [N_PORTS-1:0] o_gnt,
  output logic      [IDX_W-1:0]   o_idx,
  output logic                    o_valid
);

  logic [N_PORTS-1:0] w_gnt;
  logic               w_found;
  logic [7:0]         w_oh;
  logic [2:0]         w_idx3;
  int                 w_j;

  // Scan ports starting at the pointer; the first requester wins
  always_comb begin
    w_gnt   = '0;
    w_found = 1'b0;
    w_j     = 0;
    for (int i = 0; i < N_PORTS; i++) begin
      w_j = int'(i_ptr) + i;
      if (w_j >= N_PORTS) w_j = w_j - N_PORTS;
      if (i_en && !w_found && i_req[w_j]) begin
        w_gnt[w_j] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end

  // Convert the one-hot grant to an index for the data muxes
  always_comb begin
    w_oh                = '0;
    w_oh[N_PORTS-1:0]   = w_gnt;
    w_idx3              = onehot_to_idx(w_oh);
  end

  assign o_gnt   = w_gnt;
  assign o_idx   = w_idx3[IDX_W-1:0];
  assign o_valid = w_found;

endmodule
`default_nettype wire

// File: rtl/l2_bank_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : l2_bank_port_arbiter
// Purpose  : Round-robin sharing of one single-port L2 SRAM bank between
//            N_PORTS requesters, with a zero-fill init sweep sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module l2_bank_port_arbiter
  import l2_arb_pkg::*;
#(
  parameter int N_PORTS   = 4,
  parameter int ADDR_W    = 15,
  parameter int DATA_W    = 32,
  parameter int MEM_WORDS = 28672
) (
  input  wire logic                clk_i,
  input  wire logic                rst_i,
  input  wire logic                init_req_i,
  output logic                     init_busy_o,
  output logic                     init_done_o,
  l2_bank_port_arbiter_if.slave    bus,
  output logic                     mem_cen_o,
  output logic                     mem_wen_o,
  output logic [DATA_W/8-1:0]      mem_ben_o,
  output logic [ADDR_W-1:0]        mem_a_o,
  output logic [DATA_W-1:0]        mem_d_o,
  input  wire logic [DATA_W-1:0]   mem_q_i
);

  localparam int                c_BYTES = DATA_W / 8;
  localparam int                c_IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam logic [ADDR_W-1:0] c_LAST  = ADDR_W'(MEM_WORDS - 1);
  localparam logic [c_IDX_W-1:0] c_PMAX = c_IDX_W'(N_PORTS - 1);

  arb_state_t          r_state;
  logic [ADDR_W-1:0]   r_cnt;
  logic [c_IDX_W-1:0]  r_ptr;
  logic [N_PORTS-1:0]  r_rvalid;
  logic                r_wen;
  logic [c_BYTES-1:0]  r_ben;
  logic [ADDR_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_d;

  logic [N_PORTS-1:0]  w_gnt;
  logic [c_IDX_W-1:0]  w_idx;
  logic                w_gnt_any;
  logic                w_cen;
  logic                w_wen;
  logic [c_BYTES-1:0]  w_ben;
  logic [ADDR_W-1:0]   w_a;
  logic [DATA_W-1:0]   w_d;

  l2_rr_arb #(
    .N_PORTS (N_PORTS),
    .IDX_W   (c_IDX_W)
  ) u_rr_arb (
    .i_req   (bus.req_i),
    .i_ptr   (r_ptr),
    .i_en    (r_state == c_ST_IDLE),
    .o_gnt   (w_gnt),
    .o_idx   (w_idx),
    .o_valid (w_gnt_any)
  );

  // Bank command mux: granted port, sweep write, or hold last values when idle
  always_comb begin
    w_cen = 1'b1;
    w_wen = r_wen;
    w_ben = r_ben;
    w_a   = r_a;
    w_d   = r_d;
    case (r_state)
      c_ST_IDLE: begin
        if (w_gnt_any) begin
          w_cen = 1'b0;
          w_wen = ~bus.we_i[w_idx];
          w_ben = ~bus.be_i[int'(w_idx)*c_BYTES +: c_BYTES];
          w_a   = bus.addr_i[int'(w_idx)*ADDR_W +: ADDR_W];
          w_d   = bus.wdata_i[int'(w_idx)*DATA_W +: DATA_W];
        end
      end
      c_ST_CLEAR: begin
        w_cen = 1'b0;
        w_wen = 1'b0;
        w_ben = '0;
        w_a   = r_cnt;
        w_d   = '0;
      end
      default: ;
    endcase
  end

  // Sequencer: idle arbitration, sweep counter and done pulse
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= c_ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (init_req_i) r_state <= c_ST_CLEAR;
        end
        c_ST_CLEAR: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_LAST) r_state <= c_ST_DONE;
        end
        c_ST_DONE: begin
          r_cnt   <= '0;
          r_state <= c_ST_IDLE;
        end
        default: begin
          r_cnt   <= '0;
          r_state <= c_ST_IDLE;
        end
      endcase
    end
  end

  // Round-robin pointer moves past the port just granted; responses lag by one
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr    <= '0;
      r_rvalid <= '0;
    end else begin
      r_rvalid <= w_gnt;
      if (w_gnt_any) r_ptr <= (w_idx == c_PMAX) ? '0 : w_idx + 1'b1;
    end
  end

  // Remember the last driven bank command so idle cycles do not toggle pins
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wen <= 1'b1;
      r_ben <= '1;
      r_a   <= '0;
      r_d   <= '0;
    end else if (!w_cen) begin
      r_wen <= w_wen;
      r_ben <= w_ben;
      r_a   <= w_a;
      r_d   <= w_d;
    end
  end

  assign bus.gnt_o    = w_gnt;
  assign bus.rvalid_o = r_rvalid;
  assign bus.rdata_o  = mem_q_i;
  assign init_busy_o  = (r_state == c_ST_CLEAR);
  assign init_done_o  = (r_state == c_ST_DONE);
  assign mem_cen_o    = w_cen;
  assign mem_wen_o    = w_wen;
  assign mem_ben_o    = w_ben;
  assign mem_a_o      = w_a;
  assign mem_d_o      = w_d;

endmodule
`default_nettype wire

// File: tb/tb_l2_bank_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_l2_bank_port_arbiter
// Purpose  : Directed self-checking bench for l2_bank_port_arbiter with a
//            behavioural single-port SRAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_l2_bank_port_arbiter;

  localparam int N   = 4;
  localparam int AW  = 15;
  localparam int DW  = 32;
  localparam int BW  = DW / 8;
  localparam int MW  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          init_req = 1'b0;
  logic          init_busy;
  logic          init_done;
  logic          mem_cen;
  logic          mem_wen;
  logic [BW-1:0] mem_ben;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_d;
  logic [DW-1:0] mem_q = '0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int checks = 0;
  int errors = 0;

  l2_bank_port_arbiter_if #(.N_PORTS(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  l2_bank_port_arbiter #(
    .N_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .MEM_WORDS(MW)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .init_req_i  (init_req),
    .init_busy_o (init_busy),
    .init_done_o (init_done),
    .bus         (bus),
    .mem_cen_o   (mem_cen),
    .mem_wen_o   (mem_wen),
    .mem_ben_o   (mem_ben),
    .mem_a_o     (mem_a),
    .mem_d_o     (mem_d),
    .mem_q_i     (mem_q)
  );

  always #5 clk = ~clk;

  // SRAM model: active-low controls, one-cycle read latency
  always @(posedge clk) begin
    if (!mem_cen) begin
      if (!mem_wen) begin
        for (int b = 0; b < BW; b++)
          if (!mem_ben[b]) mem[mem_a][b*8 +: 8] <= mem_d[b*8 +: 8];
      end else begin
        mem_q <= mem[mem_a];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ports();
    bus.req_i   = '0;
    bus.we_i    = '0;
    bus.be_i    = '0;
    bus.addr_i  = '0;
    bus.wdata_i = '0;
  endtask

  task automatic set_port(input int k, input logic we, input logic [BW-1:0] be,
                          input logic [AW-1:0] a, input logic [DW-1:0] wd);
    bus.req_i[k]            = 1'b1;
    bus.we_i[k]             = we;
    bus.be_i[k*BW +: BW]    = be;
    bus.addr_i[k*AW +: AW]  = a;
    bus.wdata_i[k*DW +: DW] = wd;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    init_req = 1'b0;
    clear_ports();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (bus.rvalid_o !== 4'b0000) begin
      errors++; $display("FAIL reset_rvalid got %b want 0000", bus.rvalid_o);
    end
    checks++;
    if ({init_busy, init_done} !== 2'b00) begin
      errors++; $display("FAIL reset_init got %b want 00", {init_busy, init_done});
    end
    checks++;
    if ({bus.gnt_o, mem_cen} !== 5'b0000_1) begin
      errors++; $display("FAIL reset_idle gnt/cen got %b want 00001", {bus.gnt_o, mem_cen});
    end
    tick();
  endtask

  task automatic test_single_read();
    set_port(2, 1'b0, 4'hF, 15'h0123, '0);
    #1;
    checks++;
    if ({bus.gnt_o, mem_cen, mem_wen, mem_a} !== {4'b0100, 1'b0, 1'b1, 15'h0123}) begin
      errors++; $display("FAIL read_cmd got gnt=%b cen=%b wen=%b a=%h want 0100 0 1 0123",
                         bus.gnt_o, mem_cen, mem_wen, mem_a);
    end
    tick();
    clear_ports();
    #1;
    checks++;
    if ({bus.rvalid_o, bus.rdata_o} !== {4'b0100, 32'hDEADBEEF}) begin
      errors++; $display("FAIL read_resp got rvalid=%b rdata=%h want 0100 deadbeef",
                         bus.rvalid_o, bus.rdata_o);
    end
    checks++;
    if ({mem_cen, mem_wen, mem_a} !== {1'b1, 1'b1, 15'h0123}) begin
      errors++; $display("FAIL idle_hold got cen=%b wen=%b a=%h want 1 1 0123",
                         mem_cen, mem_wen, mem_a);
    end
    tick();
  endtask

  task automatic test_fairness();
    logic [N-1:0] exp_g;
    logic [N-1:0] prev_g;
    do_reset();
    prev_g = '0;
    for (int k = 0; k < N; k++) set_port(k, 1'b0, 4'hF, 15'(k), '0);
    for (int i = 0; i < 8; i++) begin
      exp_g = 4'b0001 << (i % N);
      #1;
      checks++;
      if ({bus.gnt_o, bus.rvalid_o} !== {exp_g, prev_g}) begin
        errors++; $display("FAIL fair_cycle%0d got gnt=%b rvalid=%b want %b %b",
                           i, bus.gnt_o, bus.rvalid_o, exp_g, prev_g);
      end
      prev_g = exp_g;
      tick();
    end
    clear_ports();
    #1;
    checks++;
    if (bus.rvalid_o !== 4'b1000) begin
      errors++; $display("FAIL fair_tail rvalid got %b want 1000", bus.rvalid_o);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    set_port(1, 1'b0, 4'hF, 15'h0040, '0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({bus.gnt_o, bus.rvalid_o} !== {4'b0010, (i == 0) ? 4'b0000 : 4'b0010}) begin
        errors++; $display("FAIL b2b_cycle%0d got gnt=%b rvalid=%b", i, bus.gnt_o, bus.rvalid_o);
      end
      tick();
    end
    clear_ports();
    tick();
  endtask

  task automatic test_byte_write();
    set_port(1, 1'b1, 4'b0101, 15'h0010, 32'hAABBCCDD);
    #1;
    checks++;
    if ({bus.gnt_o, mem_wen, mem_ben, mem_d} !== {4'b0010, 1'b0, 4'b1010, 32'hAABBCCDD}) begin
      errors++; $display("FAIL bwrite_cmd got gnt=%b wen=%b ben=%b d=%h want 0010 0 1010 aabbccdd",
                         bus.gnt_o, mem_wen, mem_ben, mem_d);
    end
    tick();
    clear_ports();
    set_port(1, 1'b0, 4'hF, 15'h0010, '0);
    #1;
    checks++;
    if ({bus.gnt_o, bus.rvalid_o, mem_wen} !== {4'b0010, 4'b0010, 1'b1}) begin
      errors++; $display("FAIL bwrite_readcmd got gnt=%b rvalid=%b wen=%b",
                         bus.gnt_o, bus.rvalid_o, mem_wen);
    end
    tick();
    clear_ports();
    #1;
    checks++;
    if (bus.rdata_o !== 32'h00BB00DD) begin
      errors++; $display("FAIL bwrite_data got %h want 00bb00dd", bus.rdata_o);
    end
    tick();
  endtask

  task automatic test_init_sweep();
    set_port(0, 1'b0, 4'hF, 15'h0000, '0);
    init_req = 1'b1;
    #1;
    checks++;
    if (bus.gnt_o !== 4'b0001) begin
      errors++; $display("FAIL sweep_entry_gnt got %b want 0001", bus.gnt_o);
    end
    tick();
    init_req = 1'b0;
    for (int i = 0; i < MW; i++) begin
      #1;
      checks++;
      if ({bus.gnt_o, mem_cen, mem_wen, mem_ben, mem_a, mem_d, init_busy, init_done} !==
          {4'b0000, 1'b0, 1'b0, 4'b0000, 15'(i), 32'h0, 1'b1, 1'b0}) begin
        errors++; $display("FAIL sweep_cycle%0d got gnt=%b cen=%b wen=%b ben=%b a=%h d=%h busy=%b done=%b",
                           i, bus.gnt_o, mem_cen, mem_wen, mem_ben, mem_a, mem_d, init_busy, init_done);
      end
      checks++;
      if (bus.rvalid_o !== ((i == 0) ? 4'b0001 : 4'b0000)) begin
        errors++; $display("FAIL sweep_rvalid%0d got %b", i, bus.rvalid_o);
      end
      tick();
    end
    #1;
    checks++;
    if ({init_done, init_busy, mem_cen, bus.gnt_o} !== {1'b1, 1'b0, 1'b1, 4'b0000}) begin
      errors++; $display("FAIL sweep_done got done=%b busy=%b cen=%b gnt=%b want 1 0 1 0000",
                         init_done, init_busy, mem_cen, bus.gnt_o);
    end
    tick();
    #1;
    checks++;
    if ({bus.gnt_o, init_done} !== {4'b0001, 1'b0}) begin
      errors++; $display("FAIL sweep_resume got gnt=%b done=%b want 0001 0", bus.gnt_o, init_done);
    end
    tick();
    clear_ports();
    checks++;
    if (mem[5] !== 32'h0) begin
      errors++; $display("FAIL sweep_cleared mem[5] got %h want 0", mem[5]);
    end
    tick();
  endtask

  task automatic test_overlap();
    bit seen;
    set_port(3, 1'b0, 4'hF, 15'h0123, '0);
    init_req = 1'b1;
    #1;
    checks++;
    if (bus.gnt_o !== 4'b1000) begin
      errors++; $display("FAIL ovl_gnt got %b want 1000", bus.gnt_o);
    end
    tick();
    init_req = 1'b0;
    clear_ports();
    #1;
    checks++;
    if ({bus.rvalid_o, init_busy, bus.rdata_o} !== {4'b1000, 1'b1, 32'hDEADBEEF}) begin
      errors++; $display("FAIL ovl_resp got rvalid=%b busy=%b rdata=%h want 1000 1 deadbeef",
                         bus.rvalid_o, init_busy, bus.rdata_o);
    end
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (init_done) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL ovl_done_timeout got done=0 want 1 within 40 cycles");
    end
    tick();
  endtask

  task automatic test_reset_mid_sweep();
    bit bad;
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if ({init_busy, mem_a} !== {1'b1, 15'd5}) begin
      errors++; $display("FAIL mid_counter got busy=%b a=%h want 1 0005", init_busy, mem_a);
    end
    rst = 1'b1;
    for (int k = 0; k < N; k++) set_port(k, 1'b0, 4'hF, 15'(k), '0);
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({init_busy, init_done, bus.rvalid_o, bus.gnt_o} !== {1'b0, 1'b0, 4'b0000, 4'b0001}) begin
      errors++; $display("FAIL mid_reset got busy=%b done=%b rvalid=%b gnt=%b want 0 0 0000 0001",
                         init_busy, init_done, bus.rvalid_o, bus.gnt_o);
    end
    clear_ports();
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (init_done || init_busy) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL mid_no_done got busy/done activity want none");
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem[15'h0123] = 32'hDEADBEEF;
    mem[5]        = 32'h5555_5555;
    clear_ports();
    test_reset();
    test_single_read();
    test_fairness();
    test_back_to_back();
    test_byte_write();
    test_init_sweep();
    test_overlap();
    test_reset_mid_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/l2_bank_port_arbiter.md
Name: l2_bank_port_arbiter

Overview:
Shares one single-port L2 SRAM bank (CEN/WEN/BEN/A/D/Q interface, active-low controls, 1-cycle read latency) between N_PORTS requesters using round-robin arbitration. Returns read data and per-port response valids one cycle after each grant. Has a zero-fill init sequencer that sweeps the whole bank after boot or on request and blocks requesters while it runs. Sits between the SoC interconnect ports and one L2 memory macro wrapper.

Parameters:
N_PORTS, 4, number of requesters (2..8)
ADDR_W, 15, word address width
DATA_W, 32, data width (BEN width = DATA_W/8)
MEM_WORDS, 28672, words cleared by the init sweep (at most 2**ADDR_W)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
init_req_i  in  1  start zero-fill sweep (level-sampled in IDLE)
init_busy_o  out  1  high while sweep runs
init_done_o  out  1  one-cycle pulse on sweep completion
req_i  in  N_PORTS  per-port request
we_i  in  N_PORTS  per-port write enable, active high
be_i  in  N_PORTS*DATA_W/8  per-port byte enables, active high
addr_i  in  N_PORTS*ADDR_W  per-port word address
wdata_i  in  N_PORTS*DATA_W  per-port write data
gnt_o  out  N_PORTS  one-hot grant, combinational
rvalid_o  out  N_PORTS  one-hot response valid, 1 cycle after grant
rdata_o  out  DATA_W  response data, equals mem_q_i
mem_cen_o  out  1  bank chip enable, active low
mem_wen_o  out  1  bank write enable, active low (0 = write)
mem_ben_o  out  DATA_W/8  bank byte enables, active low
mem_a_o  out  ADDR_W  bank address
mem_d_o  out  DATA_W  bank write data
mem_q_i  in  DATA_W  bank read data, valid the cycle after access

Behaviour:
- Reset (rst_i=1 at clk_i edge): state IDLE, rr pointer 0, rvalid_o 0, init_busy_o 0, init_done_o 0, sweep counter 0. The sweep does not start automatically; boot code or the PMU asserts init_req_i.
- IDLE arbitration: gnt_o grants the first requesting port at or after the rr pointer, cyclically. At most one grant per cycle. No request -> gnt_o=0 and mem_cen_o=1.
- On a grant to port k: mem_cen_o=0, mem_wen_o=~we_i[k], mem_ben_o=~be_i[k], mem_a_o=addr_i[k], mem_d_o=wdata_i[k], all combinational. The rr pointer becomes (k+1) mod N_PORTS at the next edge.
- Response: rvalid_o[k]=1 exactly one cycle after a grant to k, for reads and writes. rdata_o = mem_q_i, meaningful only for reads. A port may be granted back-to-back; throughput is 1 access per cycle.
- If no port is granted, mem_* outputs other than mem_cen_o hold their previous values (no toggling) to save power.
- FSM states IDLE, CLEAR, DONE:
  - IDLE -> CLEAR when init_req_i=1. That cycle still arbitrates normally.
  - CLEAR: gnt_o=0; mem_cen_o=0, mem_wen_o=0, mem_ben_o all 0, mem_a_o=counter, mem_d_o=0. Counter increments each cycle. After writing address MEM_WORDS-1 -> DONE. init_busy_o=1 throughout CLEAR.
  - DONE (1 cycle): init_done_o=1, gnt_o=0, mem_cen_o=1, counter cleared -> IDLE.
- The sweep takes exactly MEM_WORDS cycles in CLEAR plus 1 DONE cycle.
- A response owed from the grant in the IDLE->CLEAR transition cycle is still delivered in the first CLEAR cycle.
- init_req_i is ignored in CLEAR and DONE. Holding init_req_i high in IDLE restarts the sweep.
- Sweep writes never raise rvalid_o.
- rst_i mid-sweep aborts it: state IDLE, counter 0, no init_done_o pulse, pending rvalid dropped.
- Requests held during CLEAR are neither granted nor lost. Requesters must hold req_i until gnt_o.

Decomposition:
- Package l2_arb_pkg: state enum (IDLE, CLEAR, DONE), BE_W = DATA_W/8 constant, helper function for the one-hot-to-index conversion.
- Sub-module l2_rr_arb: N_PORTS round-robin arbiter taking req, pointer and enable, producing a one-hot grant and a grant index.
- Top level holds the FSM, sweep counter, mem mux and rvalid register.

Test Plan:
- Single read: port 2 req, we=0, addr=0x0123. Expect gnt_o=4'b0100 the same cycle, mem_cen_o=0, mem_wen_o=1, mem_a_o=0x0123. Next cycle rvalid_o=4'b0100 and rdata_o=mem_q_i (0xDEADBEEF from the model).
- Fairness: all 4 ports request continuously for 8 cycles from reset. Expect grants in order 0,1,2,3,0,1,2,3 and each rvalid lagging its grant by 1 cycle.
- Byte write: port 1 writes 0xAABBCCDD to 0x10 with be=4'b0101, then reads 0x10 (prior content 0x0). Expect mem_ben_o=4'b1010 on the write and read data 0x00BB00DD.
- Init sweep with MEM_WORDS=16: pulse init_req_i, with port 0 requesting throughout. Expect 16 CLEAR cycles writing addresses 0..15 with data 0 and ben 0, gnt_o=0, init_busy_o=1. Then a 1-cycle init_done_o pulse, and port 0 granted the first cycle back in IDLE.
- Transition overlap: port 3 read granted in the same cycle init_req_i rises. Expect rvalid_o[3]=1 in the first CLEAR cycle.
- Reset mid-sweep: assert rst_i at counter=5. Expect IDLE next cycle, init_busy_o=0, no init_done_o pulse, rvalid_o=0, and the rr pointer restarting at port 0.
